// File: rtl/hazard_unit.sv
// Pipeline hazard tracker: follows X/M/W destinations, detects load-use and
// multdiv stalls, and selects X-stage operand bypass sources.
module hazard_unit (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic [4:0] d_rd,
  input  logic       d_valid,
  input  logic       d_writes,
  input  logic       d_is_load,
  input  logic       flush,
  input  logic       md_start,
  input  logic       md_ready,
  output logic       stall,
  output logic [4:0] x_rd,
  output logic [4:0] m_rd,
  output logic [4:0] w_rd,
  output logic [1:0] byp_a_sel,
  output logic [1:0] byp_b_sel
);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  typedef struct packed {
    logic       valid;
    logic       writes;
    logic       is_load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } x_slot_t;

  // Past X only the destination matters; load-ness and sources are never read again.
  typedef struct packed {
    logic       valid;
    logic       writes;
    logic [4:0] rd;
  } slot_t;

  state_t  state;
  x_slot_t x_q;
  slot_t   m_q;
  slot_t   w_q;
  x_slot_t dec_slot;
  logic    load_use;

  function automatic slot_t retire(input x_slot_t s);
    slot_t r;
    r.valid  = s.valid;
    r.writes = s.writes;
    r.rd     = s.rd;
    return r;
  endfunction

  function automatic logic [4:0] dest(input slot_t s);
    return (s.valid & s.writes) ? s.rd : 5'd0;
  endfunction

  // Younger producer in M wins over W; r0 is never forwarded.
  function automatic logic [1:0] bypass(input logic [4:0] rs, input slot_t m, input slot_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (m.valid & m.writes & (m.rd == rs))
        sel = 2'b01;
      else if (w.valid & w.writes & (w.rd == rs))
        sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = d_valid & x_q.valid & x_q.is_load & x_q.writes &
               ((x_q.rd == d_rs1) | (x_q.rd == d_rs2));
  end

  always_comb begin
    stall = (state == MD_BUSY) | load_use;
  end

  // A squashed, absent or stalled decode instruction enters X as a bubble.
  always_comb begin
    dec_slot = '0;
    if (d_valid & ~flush & ~load_use) begin
      dec_slot.valid   = 1'b1;
      dec_slot.writes  = d_writes & (d_rd != 5'd0);
      dec_slot.is_load = d_is_load;
      dec_slot.rd      = d_rd;
      dec_slot.rs1     = d_rs1;
      dec_slot.rs2     = d_rs2;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      x_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          w_q <= m_q;
          m_q <= retire(x_q);
          x_q <= dec_slot;
          if (md_start)
            state <= MD_BUSY;
        end
        MD_BUSY: begin
          // The multdiv op stays parked in X while older work drains out.
          w_q <= m_q;
          m_q <= '0;
          if (md_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    x_rd      = dest(retire(x_q));
    m_rd      = dest(m_q);
    w_rd      = dest(w_q);
    byp_a_sel = bypass(x_q.rs1, m_q, w_q);
    byp_b_sel = bypass(x_q.rs2, m_q, w_q);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a queue-of-instructions reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       d_valid, d_writes, d_is_load;
  logic       flush, md_start, md_ready;
  logic       stall;
  logic [4:0] x_rd, m_rd, w_rd;
  logic [1:0] byp_a_sel, byp_b_sel;

  int total = 0;
  int bad   = 0;

  hazard_unit dut (
    .clk(clk), .clr(clr),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_valid(d_valid), .d_writes(d_writes), .d_is_load(d_is_load),
    .flush(flush), .md_start(md_start), .md_ready(md_ready),
    .stall(stall), .x_rd(x_rd), .m_rd(m_rd), .w_rd(w_rd),
    .byp_a_sel(byp_a_sel), .byp_b_sel(byp_b_sel)
  );

  always #5 clk = ~clk;

  // Reference model: pipe[0]=X, pipe[1]=M, pipe[2]=W, plus a multdiv busy flag.
  typedef struct packed {
    logic       valid;
    logic       writes;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ins_t;

  ins_t pipe [3];
  logic busy_m;

  function automatic logic model_stall(input ins_t x, input logic busy, input logic dv,
                                       input logic [4:0] r1, input logic [4:0] r2);
    return busy || (dv && x.valid && x.ld && x.writes && (x.rd == r1 || x.rd == r2));
  endfunction

  function automatic logic [1:0] model_sel(input logic [4:0] rs, input ins_t m, input ins_t w);
    logic [1:0] s;
    s = 2'b00;
    if (rs != 0 && w.valid && w.writes && w.rd == rs) s = 2'b10;
    if (rs != 0 && m.valid && m.writes && m.rd == rs) s = 2'b01;
    return s;
  endfunction

  function automatic logic [4:0] model_rd(input ins_t s);
    return (s.valid && s.writes) ? s.rd : 5'd0;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
      busy_m <= 1'b0;
    end else if (busy_m) begin
      pipe[2] <= pipe[1];
      pipe[1] <= '0;
      if (md_ready) busy_m <= 1'b0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      if (model_stall(pipe[0], 1'b0, d_valid, d_rs1, d_rs2) || flush || !d_valid)
        pipe[0] <= '0;
      else
        pipe[0] <= {1'b1, d_writes && (d_rd != 0), d_is_load, d_rd, d_rs1, d_rs2};
      if (md_start) busy_m <= 1'b1;
    end
  end

  task automatic set_dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic wr, input logic ld);
    d_valid = v; d_rs1 = r1; d_rs2 = r2; d_rd = rd; d_writes = wr; d_is_load = ld;
  endtask

  task automatic drain();
    set_dec(0, 0, 0, 0, 0, 0);
    flush = 0; md_start = 0; md_ready = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%0d exp=0", stall); end
    total++; if ({x_rd, m_rd, w_rd} !== 15'd0) begin bad++; $display("[TB] FAIL rst_rd got=%0d/%0d/%0d exp=0/0/0", x_rd, m_rd, w_rd); end
    total++; if ({byp_a_sel, byp_b_sel} !== 4'd0) begin bad++; $display("[TB] FAIL rst_byp got=%0d/%0d exp=0/0", byp_a_sel, byp_b_sel); end
    clr = 0;
    @(negedge clk); #1;
    total++; if (stall !== 1'b0 || x_rd !== 5'd0) begin bad++; $display("[TB] FAIL post_rst got stall=%0d x_rd=%0d exp 0/0", stall, x_rd); end
  endtask

  task automatic test_load_use();
    drain();
    set_dec(1, 0, 0, 5, 1, 1); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_first got=%0d exp=0", stall); end
    @(negedge clk); set_dec(1, 5, 0, 6, 1, 0); #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0d exp=1", stall); end
    total++; if (x_rd !== 5'd5) begin bad++; $display("[TB] FAIL lu_xrd got=%0d exp=5", x_rd); end
    @(negedge clk); #1;
    total++; if (stall !== 1'b0 || x_rd !== 5'd0 || m_rd !== 5'd5) begin bad++; $display("[TB] FAIL lu_bubble got stall=%0d x_rd=%0d m_rd=%0d exp 0/0/5", stall, x_rd, m_rd); end
    @(negedge clk); set_dec(0, 0, 0, 0, 0, 0); #1;
    total++; if (byp_a_sel !== 2'b10 || x_rd !== 5'd6 || w_rd !== 5'd5) begin bad++; $display("[TB] FAIL lu_byp got sel=%0d x_rd=%0d w_rd=%0d exp 2/6/5", byp_a_sel, x_rd, w_rd); end
    @(negedge clk); #1;
    total++; if (byp_a_sel !== 2'b00) begin bad++; $display("[TB] FAIL lu_byp_gone got=%0d exp=0", byp_a_sel); end
  endtask

  task automatic test_forward();
    drain();
    set_dec(1, 1, 2, 3, 1, 0);
    @(negedge clk); set_dec(1, 4, 3, 8, 1, 0); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL fwd_stall got=%0d exp=0", stall); end
    @(negedge clk); set_dec(1, 1, 2, 3, 1, 0); #1;
    total++; if (byp_b_sel !== 2'b01 || byp_a_sel !== 2'b00) begin bad++; $display("[TB] FAIL fwd_m got=%0d/%0d exp=0/1", byp_a_sel, byp_b_sel); end
    @(negedge clk); set_dec(1, 1, 2, 10, 1, 0);
    @(negedge clk); set_dec(1, 4, 3, 8, 1, 0);
    @(negedge clk); set_dec(0, 0, 0, 0, 0, 0); #1;
    total++; if (byp_b_sel !== 2'b10 || byp_a_sel !== 2'b00) begin bad++; $display("[TB] FAIL fwd_w got=%0d/%0d exp=0/2", byp_a_sel, byp_b_sel); end
  endtask

  task automatic test_zero_reg();
    drain();
    set_dec(1, 0, 0, 7, 1, 0);
    @(negedge clk);
    @(negedge clk); set_dec(1, 7, 0, 12, 1, 0);
    @(negedge clk); set_dec(1, 0, 0, 0, 1, 1); #1;
    total++; if (byp_a_sel !== 2'b01) begin bad++; $display("[TB] FAIL zr_mprio got=%0d exp=1", byp_a_sel); end
    @(negedge clk); set_dec(1, 0, 0, 13, 1, 0); #1;
    total++; if (stall !== 1'b0 || x_rd !== 5'd0) begin bad++; $display("[TB] FAIL zr_nostall got stall=%0d x_rd=%0d exp 0/0", stall, x_rd); end
    @(negedge clk); set_dec(0, 0, 0, 0, 0, 0); #1;
    total++; if (byp_a_sel !== 2'b00 || byp_b_sel !== 2'b00 || x_rd !== 5'd13) begin bad++; $display("[TB] FAIL zr_nobyp got=%0d/%0d x_rd=%0d exp 0/0/13", byp_a_sel, byp_b_sel, x_rd); end
  endtask

  task automatic test_flush();
    drain();
    set_dec(1, 1, 2, 4, 1, 0); flush = 1;
    @(negedge clk); flush = 0; #1;
    total++; if (x_rd !== 5'd0) begin bad++; $display("[TB] FAIL flush_xrd got=%0d exp=0", x_rd); end
    @(negedge clk); set_dec(0, 0, 0, 0, 0, 0); #1;
    total++; if (x_rd !== 5'd4) begin bad++; $display("[TB] FAIL noflush_xrd got=%0d exp=4", x_rd); end
  endtask

  task automatic test_multdiv();
    drain();
    set_dec(1, 1, 2, 9, 1, 0); md_start = 1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL md_enter got=%0d exp=0", stall); end
    @(negedge clk); md_start = 0; set_dec(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) md_ready = 1;
      #1;
      total++; if (stall !== 1'b1 || x_rd !== 5'd9 || m_rd !== 5'd0) begin bad++; $display("[TB] FAIL md_busy%0d got stall=%0d x_rd=%0d m_rd=%0d exp 1/9/0", i, stall, x_rd, m_rd); end
    end
    @(negedge clk); md_ready = 0; #1;
    total++; if (stall !== 1'b0 || x_rd !== 5'd9) begin bad++; $display("[TB] FAIL md_exit got stall=%0d x_rd=%0d exp 0/9", stall, x_rd); end
    @(negedge clk); #1;
    total++; if (m_rd !== 5'd9 || x_rd !== 5'd0) begin bad++; $display("[TB] FAIL md_adv got m_rd=%0d x_rd=%0d exp 9/0", m_rd, x_rd); end
  endtask

  task automatic test_clr_mid_busy();
    drain();
    set_dec(1, 1, 2, 11, 1, 0);
    @(negedge clk); set_dec(1, 1, 2, 9, 1, 0); md_start = 1;
    @(negedge clk); md_start = 0; set_dec(0, 0, 0, 0, 0, 0); #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL cb_busy got=%0d exp=1", stall); end
    @(negedge clk); #1;
    total++; if (w_rd !== 5'd11 || x_rd !== 5'd9) begin bad++; $display("[TB] FAIL cb_pre got w_rd=%0d x_rd=%0d exp 11/9", w_rd, x_rd); end
    #1 clr = 1; #1;
    total++; if (stall !== 1'b0 || {x_rd, m_rd, w_rd} !== 15'd0) begin bad++; $display("[TB] FAIL cb_clr got stall=%0d rd=%0d/%0d/%0d exp 0/0/0/0", stall, x_rd, m_rd, w_rd); end
    #1 clr = 0;
    @(negedge clk); md_ready = 1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL cb_after got=%0d exp=0", stall); end
    @(negedge clk); md_ready = 0; #1;
    total++; if (stall !== 1'b0 || x_rd !== 5'd0) begin bad++; $display("[TB] FAIL cb_ready got stall=%0d x_rd=%0d exp 0/0", stall, x_rd); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      set_dec(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      flush    = ($urandom_range(0, 7) == 0);
      md_start = ($urandom_range(0, 9) == 0);
      md_ready = ($urandom_range(0, 3) == 0);
      #1;
      total++; if (stall !== model_stall(pipe[0], busy_m, d_valid, d_rs1, d_rs2)) begin bad++; $display("[TB] FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall, model_stall(pipe[0], busy_m, d_valid, d_rs1, d_rs2)); end
      total++; if (byp_a_sel !== model_sel(pipe[0].rs1, pipe[1], pipe[2])) begin bad++; $display("[TB] FAIL rnd_byp_a n=%0d got=%0d exp=%0d", n, byp_a_sel, model_sel(pipe[0].rs1, pipe[1], pipe[2])); end
      total++; if (byp_b_sel !== model_sel(pipe[0].rs2, pipe[1], pipe[2])) begin bad++; $display("[TB] FAIL rnd_byp_b n=%0d got=%0d exp=%0d", n, byp_b_sel, model_sel(pipe[0].rs2, pipe[1], pipe[2])); end
      total++; if (x_rd !== model_rd(pipe[0])) begin bad++; $display("[TB] FAIL rnd_x_rd n=%0d got=%0d exp=%0d", n, x_rd, model_rd(pipe[0])); end
      total++; if (m_rd !== model_rd(pipe[1])) begin bad++; $display("[TB] FAIL rnd_m_rd n=%0d got=%0d exp=%0d", n, m_rd, model_rd(pipe[1])); end
      total++; if (w_rd !== model_rd(pipe[2])) begin bad++; $display("[TB] FAIL rnd_w_rd n=%0d got=%0d exp=%0d", n, w_rd, model_rd(pipe[2])); end
    end
    set_dec(0, 0, 0, 0, 0, 0);
    flush = 0; md_start = 0; md_ready = 0;
  endtask

  initial begin
    clr = 1;
    set_dec(0, 0, 0, 0, 0, 0);
    flush = 0; md_start = 0; md_ready = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_forward();
    test_zero_reg();
    test_flush();
    test_multdiv();
    test_clr_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
